// File: rtl/bike_bram_port_arbiter_pkg.sv
// bike_bram_port_arbiter_pkg: BIKE BRAM port widths, arbiter sizing, owner tag and state types
package bike_bram_port_arbiter_pkg;
   localparam int B_WIDTH            = 32;
   localparam int LOGSWORDS          = 8;
   localparam int BRAM_ARB_NREQ      = 4;
   localparam int BRAM_ARB_MAX_BURST = 16;
   typedef logic [$clog2(BRAM_ARB_NREQ)-1:0] owner_t;
   typedef enum logic {ARB_IDLE, ARB_OWN} arb_state_t;
   function automatic logic [BRAM_ARB_NREQ-1:0] owner_onehot(owner_t k);
      return BRAM_ARB_NREQ'(1) << k;
   endfunction
endpackage

// File: rtl/bike_bram_port_arbiter_if.sv
// bike_bram_port_arbiter_if: requester-side and BRAM-side signals of the port arbiter
interface bike_bram_port_arbiter_if;
   import bike_bram_port_arbiter_pkg::*;
   logic                             sampling;
   logic [BRAM_ARB_NREQ-1:0]         req, wen_req, ren_req, gnt, rvalid;
   logic [BRAM_ARB_NREQ*LOGSWORDS-1:0] addr_req;
   logic [BRAM_ARB_NREQ*B_WIDTH-1:0] din_req;
   logic [B_WIDTH-1:0]               rdata, bram_din, bram_dout;
   logic [LOGSWORDS-1:0]             bram_addr;
   logic                             bram_wen, bram_ren, busy;
   modport slave (input sampling, req, wen_req, ren_req, addr_req, din_req, bram_dout,
                  output gnt, rvalid, rdata, bram_wen, bram_ren, bram_addr, bram_din, busy);
   modport master (output sampling, req, wen_req, ren_req, addr_req, din_req, bram_dout,
                   input gnt, rvalid, rdata, bram_wen, bram_ren, bram_addr, bram_din, busy);
endinterface

// File: rtl/bike_bram_port_arbiter_pick.sv
// bike_rr_pick: one-hot winner = first set request at or after the pointer, wrapping
module bike_rr_pick #(parameter int N = 4) (
   input  logic [N-1:0]         i_req,
   input  logic [$clog2(N)-1:0] i_ptr,
   output logic [N-1:0]         o_win,
   output logic                 o_any
);
   logic [N-1:0]   w_rot, w_first;
   logic [2*N-1:0] w_back;
   assign w_rot = N'({i_req, i_req} >> i_ptr);
   always_comb begin
      w_first = '0;
      for (int i = N-1; i >= 0; i--) if (w_rot[i]) w_first = N'(1) << i;
   end
   // rotate the winner back into requester numbering
   assign w_back = {{N{1'b0}}, w_first} << i_ptr;
   assign o_win  = w_back[N-1:0] | w_back[2*N-1:N];
   assign o_any  = |i_req;
endmodule

// File: rtl/bike_bram_port_arbiter.sv
// bike_bram_port_arbiter: round-robin burst arbiter sharing the scalable BIKE BRAM port
// among datapath requesters, with per-requester read-return tagging.
module bike_bram_port_arbiter
   import bike_bram_port_arbiter_pkg::*;
#(parameter int MAX_BURST = BRAM_ARB_MAX_BURST) (
   input logic clk,
   input logic resetn,
   bike_bram_port_arbiter_if.slave io_bus
);
   localparam int NREQ = BRAM_ARB_NREQ;
   localparam int CW   = $clog2(MAX_BURST + 1);
   arb_state_t      r_st;
   logic [NREQ-1:0] r_gnt, w_win, w_others;
   owner_t          r_own, r_ptr, r_rv_tag, w_ptr_nx, w_pick_ptr, w_win_idx;
   logic [CW-1:0]   r_cnt;
   logic            r_rv_v, w_any, w_port, w_force, w_act, w_rel, w_wen, w_ren;
   assign w_port   = (r_st == ARB_OWN) && !io_bus.sampling;
   assign w_others = io_bus.req & ~r_gnt;
   // a saturated owner yields its slot to waiters instead of issuing one more access
   assign w_force  = (r_cnt == CW'(MAX_BURST)) && |w_others;
   assign w_act    = w_port && !w_force;
   assign w_wen    = w_act && io_bus.wen_req[r_own] && io_bus.req[r_own];
   assign w_ren    = w_act && io_bus.ren_req[r_own] && io_bus.req[r_own] && !io_bus.wen_req[r_own];
   assign w_rel    = (r_st == ARB_OWN) && (!io_bus.req[r_own] || w_force);
   assign w_ptr_nx = (r_own == owner_t'(NREQ - 1)) ? '0 : r_own + 1'b1;
   assign w_pick_ptr = (r_st == ARB_OWN) ? w_ptr_nx : r_ptr;
   bike_rr_pick #(.N(NREQ)) u_pick (.i_req(w_others), .i_ptr(w_pick_ptr), .o_win(w_win), .o_any(w_any));
   always_comb begin
      w_win_idx = '0;
      for (int i = 0; i < NREQ; i++) if (w_win[i]) w_win_idx = owner_t'(i);
   end
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_st     <= ARB_IDLE;
         r_gnt    <= '0;
         r_own    <= '0;
         r_ptr    <= '0;
         r_cnt    <= '0;
         r_rv_v   <= 1'b0;
         r_rv_tag <= '0;
      end else begin
         r_rv_v   <= w_ren;
         r_rv_tag <= r_own;
         if (io_bus.sampling) begin
            r_st  <= ARB_IDLE;
            r_gnt <= '0;
         end else if (r_st == ARB_IDLE || w_rel) begin
            if (r_st == ARB_OWN) r_ptr <= w_ptr_nx;
            r_st  <= w_any ? ARB_OWN : ARB_IDLE;
            r_gnt <= w_win;
            r_own <= w_win_idx;
            r_cnt <= '0;
         end else if ((w_wen || w_ren) && r_cnt != CW'(MAX_BURST)) r_cnt <= r_cnt + 1'b1;
      end
   end
   assign io_bus.gnt       = r_gnt;
   assign io_bus.rvalid    = r_rv_v ? owner_onehot(r_rv_tag) : '0;
   assign io_bus.rdata     = io_bus.bram_dout;
   assign io_bus.bram_wen  = w_wen;
   assign io_bus.bram_ren  = w_ren;
   assign io_bus.bram_addr = w_port ? io_bus.addr_req[r_own*LOGSWORDS +: LOGSWORDS] : '0;
   assign io_bus.bram_din  = w_port ? io_bus.din_req[r_own*B_WIDTH +: B_WIDTH] : '0;
   assign io_bus.busy      = |r_gnt || r_rv_v;
endmodule
